// File: rtl/rotate_pkg.sv
// rotate_pkg: shared definitions for the pipelined rotator/shifter.
//   MODE_*  : 2-bit operation encodings carried with each item.
//   rot_ref : whole-word reference result for any width up to 64 bits,
//             computed in one step (not stage by stage).
package rotate_pkg;

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    function automatic logic [63:0] rot_ref(
        input logic [63:0]  din,
        input int unsigned  amount,
        input logic [1:0]   mode,
        input int unsigned  width = 32
    );
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] r;
        logic [63:0] top;
        int unsigned a;
        logic        sign;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        d    = din & mask;
        a    = amount % width;
        top  = d >> (width - 1);
        sign = top[0];
        r    = d;
        if (a != 0) begin
            case (mode)
                MODE_ROR: r = ((d >> a) | (d << (width - a))) & mask;
                MODE_ROL: r = ((d << a) | (d >> (width - a))) & mask;
                MODE_LSR: r = d >> a;
                default:  r = (d >> a) | (sign ? (mask & ~(mask >> a)) : '0);
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/rotate_stage.sv
// rotate_stage: one pipeline stage of the rotator. Applies the item's mode
// operation by SHIFT bit positions when its amount bit for this stage is set,
// then registers the result together with the carried amount, mode, sign and
// valid. All registers load only when i_advance is high.
//   clock, reset_n        : clock, asynchronous active-low reset
//   i_advance             : global pipeline enable
//   i_valid/data/amount/mode/sign : predecessor stage contents
//   o_valid/data/amount/mode/sign : this stage's registered contents
module rotate_stage
    import rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHIFT = 1,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_advance,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AW-1:0]    i_amount,
    input  logic [1:0]       i_mode,
    input  logic             i_sign,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [AW-1:0]    o_amount,
    output logic [1:0]       o_mode,
    output logic             o_sign
);

    localparam int unsigned BIT = $clog2(SHIFT);

    logic [WIDTH-1:0] w_op;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_amount;
    logic [1:0]       r_mode;
    logic             r_sign;

    // ASR fills from the original MSB carried from S0, not from the current
    // word, so the fill is right regardless of which earlier stages fired.
    always_comb begin
        w_op = i_data;
        if (i_amount[BIT]) begin
            unique case (i_mode)
                MODE_ROR: w_op = {i_data[SHIFT-1:0], i_data[WIDTH-1:SHIFT]};
                MODE_ROL: w_op = {i_data[WIDTH-SHIFT-1:0], i_data[WIDTH-1:WIDTH-SHIFT]};
                MODE_LSR: w_op = {{SHIFT{1'b0}}, i_data[WIDTH-1:SHIFT]};
                MODE_ASR: w_op = {{SHIFT{i_sign}}, i_data[WIDTH-1:SHIFT]};
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_amount <= '0;
            r_mode   <= '0;
            r_sign   <= 1'b0;
        end else if (i_advance) begin
            r_valid  <= i_valid;
            r_data   <= w_op;
            r_amount <= i_amount;
            r_mode   <= i_mode;
            r_sign   <= i_sign;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_amount = r_amount;
    assign o_mode   = r_mode;
    assign o_sign   = r_sign;

endmodule

// File: rtl/rotate_pipe.sv
// rotate_pipe: pipelined barrel rotator/shifter (ROR, ROL, LSR, ASR) with
// valid/ready flow control. S0 registers the inputs, then AW rotate_stage
// instances each handle one amount bit. Latency AW+1 cycles, one item per
// cycle; a stalled output freezes the whole pipeline.
//   clock, reset_n      : clock, asynchronous active-low reset
//   in_valid, in_ready  : producer handshake
//   din, amount, mode   : operand, distance 0..WIDTH-1, operation
//   out_valid, out_ready: consumer handshake
//   dout                : result, registered from the last stage
module rotate_pipe
    import rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amount,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout
);

    logic                   w_advance;
    logic [AW:0]            w_valid;
    logic [AW:0][WIDTH-1:0] w_data;
    logic [AW:0][AW-1:0]    w_amount;
    logic [AW:0][1:0]       w_mode;
    logic [AW:0]            w_sign;
    logic                   w_unused;

    logic                   r_s0_valid;
    logic [WIDTH-1:0]       r_s0_data;
    logic [AW-1:0]          r_s0_amount;
    logic [1:0]             r_s0_mode;
    logic                   r_s0_sign;

    // Bubbles are not collapsed: the whole pipe moves or holds together.
    assign w_advance = !w_valid[AW] || out_ready;
    assign in_ready  = w_advance;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s0_valid  <= 1'b0;
            r_s0_data   <= '0;
            r_s0_amount <= '0;
            r_s0_mode   <= '0;
            r_s0_sign   <= 1'b0;
        end else if (w_advance) begin
            r_s0_valid  <= in_valid;
            r_s0_data   <= din;
            r_s0_amount <= amount;
            r_s0_mode   <= mode;
            r_s0_sign   <= din[WIDTH-1];
        end
    end

    assign w_valid[0]  = r_s0_valid;
    assign w_data[0]   = r_s0_data;
    assign w_amount[0] = r_s0_amount;
    assign w_mode[0]   = r_s0_mode;
    assign w_sign[0]   = r_s0_sign;

    for (genvar k = 0; k < AW; k++) begin : g_stage
        rotate_stage #(
            .WIDTH (WIDTH),
            .SHIFT (2 ** k),
            .AW    (AW)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_advance (w_advance),
            .i_valid   (w_valid[k]),
            .i_data    (w_data[k]),
            .i_amount  (w_amount[k]),
            .i_mode    (w_mode[k]),
            .i_sign    (w_sign[k]),
            .o_valid   (w_valid[k+1]),
            .o_data    (w_data[k+1]),
            .o_amount  (w_amount[k+1]),
            .o_mode    (w_mode[k+1]),
            .o_sign    (w_sign[k+1])
        );
    end

    assign out_valid = w_valid[AW];
    assign dout      = w_data[AW];

    // Control fields leaving the last stage have no consumer.
    assign w_unused = &{1'b0, w_amount[AW], w_mode[AW], w_sign[AW]};

endmodule

// File: doc/rotate_pipe.md
# rotate_pipe

Parametrised, pipelined barrel rotator/shifter with valid/ready flow control. It generalises the fixed 4-bit right rotator to any power-of-two width and adds left rotate, logical right shift and arithmetic right shift. It has one register per shift stage and supports full-throughput streaming with backpressure. It sits between a producer and a consumer that both use the valid/ready handshake, in the same datapath role as the existing rotator.

## Interface
Parameters:
- `WIDTH`, default 32: data width. Must be a power of two, ≥ 2.
- `AW`, default `$clog2(WIDTH)`: amount width. Derived; never overridden.

Ports:
- `clock`, input, 1: sole clock. Rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the producer offers `din`/`amount`/`mode`.
- `in_ready`, output, 1: the block accepts this cycle.
- `din`, input, `WIDTH`: operand.
- `amount`, input, `AW`: shift/rotate distance, 0..WIDTH-1.
- `mode`, input, 2: 00 ROR, 01 ROL, 10 LSR, 11 ASR.
- `out_valid`, output, 1: `dout` holds a result.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `dout`, output, `WIDTH`: result.

## Operation
- A transfer occurs on an edge where valid and ready are both 1. This applies independently to the input and output sides.
- Pipeline registers:
  - S0 captures `din`, `amount`, `mode` and valid.
  - Stage k (k = 0..AW-1) produces S(k+1) from S(k). If `amount[k]` is set, stage k applies the mode operation by 2^k; otherwise it passes S(k) through.
  - `amount`, `mode` and valid travel with the data.
  - `dout`/`out_valid` are driven directly from S(AW).
- Mode operations, for distance d:
  - ROR: `dout[i] = din[(i+d) mod WIDTH]`.
  - ROL: `dout[i] = din[(i-d) mod WIDTH]`.
  - LSR: bits shifted in are 0.
  - ASR: bits shifted in equal `din[WIDTH-1]`. The sign bit is the original MSB, carried from S0.
- Composition across stages is exact: the result equals a single operation by the full `amount`.
- `amount` = 0 returns `din` unchanged in every mode.
- Flow control uses a global advance: `advance = !out_valid || out_ready`.
  - `in_ready = advance`.
  - When advance is 1, every stage loads from its predecessor. S0 loads from the inputs, with its valid set to `in_valid`.
  - When advance is 0, every stage holds.
  - Bubbles (valid = 0) propagate and are not collapsed.
- Invalid stages still compute, but their data is don't-care. `dout` is defined only while `out_valid` = 1.
- Reset (asynchronous assert, synchronous-edge release):
  - All valid bits go to 0, and all data, amount and mode registers go to 0.
  - Therefore `dout` = 0, `out_valid` = 0 and `in_ready` = 1 during and after reset.
  - Asserting reset mid-operation discards all in-flight items. No partial output is produced.

## Timing
- Latency L = AW + 1 cycles from the input transfer edge to `out_valid` = 1, with no stalls. For WIDTH = 8, L = 4. For WIDTH = 32, L = 6.
- Throughput is one item per cycle while `out_ready` = 1.
- A stall (`out_valid` = 1, `out_ready` = 0) drops `in_ready` combinationally in the same cycle. No input is accepted, and `dout` stays stable until it is taken.
- Simultaneous output take and input accept in the same cycle is legal and required.
- There are no combinational paths from `din`, `amount` or `mode` to any output. The only combinational path is `out_ready` → `in_ready`.
- `mode` and `amount` may change on every accepted item. There is no per-mode setup.

## Structure
- Package `rotate_pkg` holds:
  - the mode encodings as localparams `MODE_ROR`, `MODE_ROL`, `MODE_LSR`, `MODE_ASR`;
  - a reference function `rot_ref(din, amount, mode)` shared with the bench.
- Sub-module `rotate_stage`, parametrised by `WIDTH` and `SHIFT` (= 2^k), contains:
  - one conditional mode operation;
  - the stage register with enable `advance`;
  - the carried amount, mode, sign and valid.
- `rotate_pipe` instantiates S0, then AW `rotate_stage` instances in a generate loop, and holds the advance logic.

## Test plan
All scenarios use WIDTH = 8, L = 4.
- Reset: with `reset_n` = 0 → `dout` = 0x00, `out_valid` = 0, `in_ready` = 1. Release, then hold `in_valid` = 0 for 10 cycles → `out_valid` stays 0.
- Modes: stream `din` = 0xB4, `amount` = 3, with `mode` = ROR, ROL, LSR, ASR on 4 consecutive cycles, `out_ready` = 1 → expect 0x96, 0xA5, 0x16, 0xF6 on cycles 4–7 with no gaps.
- Boundaries: `din` = 0xB4 with `amount` = 0 in all modes → 0xB4. `din` = 0x81 with `amount` = 7: ROR → 0x03, ROL → 0xC0, LSR → 0x01, ASR → 0xFF.
- Backpressure:
  - Send 6 items back-to-back, hold `out_ready` = 0 once the first appears → `in_ready` = 0 and `dout` holds the first result for the whole stall.
  - Release → items appear in order, none lost or duplicated.
  - Each cycle, randomly toggle `out_ready` and `in_valid` → the output sequence matches `rot_ref`.
- Reset mid-flight: accept 3 items, assert `reset_n` = 0 asynchronously between edges → `out_valid` drops immediately, and no stale item appears after release.
- Parameter sweep: WIDTH = 2, 4, 32, 64 with random traffic → results match `rot_ref` and latency = `$clog2(WIDTH)` + 1.
